// File: rtl/chaos_pkg.sv
// rtl/chaos_pkg.sv - mode codes, FSM states and saturating add/sub for the chaos Euler core
package chaos_pkg;
    localparam logic MODE_LORENZ  = 1'b0;
    localparam logic MODE_ROSSLER = 1'b1;
    localparam int   Q_W          = 32;
    localparam int   Q_FRAC       = 20;
    localparam int   ACC_W        = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_M0,
        ST_M1,
        ST_M2,
        ST_M3,
        ST_UPD
    } state_e;

    typedef struct packed {
        logic                    ovf;
        logic signed [ACC_W-1:0] val;
    } sat_t;

    // Operands arrive sign-extended to ACC_W; the result is clamped to a w-bit signed range.
    function automatic sat_t sat_to(input logic signed [ACC_W-1:0] v, input int w);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        sat_t r;
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.ovf = 1'b0;
        r.val = v;
        if (v > hi) begin
            r.ovf = 1'b1;
            r.val = hi;
        end else if (v < lo) begin
            r.ovf = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

    function automatic sat_t sat_add(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b, input int w);
        return sat_to(a + b, w);
    endfunction

    function automatic sat_t sat_sub(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b, input int w);
        return sat_to(a - b, w);
    endfunction
endpackage

// File: rtl/fixed_mult_sat.sv
// rtl/fixed_mult_sat.sv - signed WxW fixed-point multiply, floor shift by FRAC, saturate to W
module fixed_mult_sat #(
    parameter int W    = 32,
    parameter int FRAC = 20
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] p_o,
    output logic                ovf_o
);
    logic signed [2*W-1:0] a_ext;
    logic signed [2*W-1:0] b_ext;
    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] shifted;
    logic        [W:0]     top_bits;

    always_comb begin
        a_ext    = {{W{a_i[W-1]}}, a_i};
        b_ext    = {{W{b_i[W-1]}}, b_i};
        prod     = a_ext * b_ext;
        shifted  = prod >>> FRAC;
        // The shifted product fits in W bits only if its top W+1 bits are all sign copies.
        top_bits = shifted[2*W-1:W-1];
        ovf_o    = !((&top_bits) || !(|top_bits));
        if (!ovf_o) begin
            p_o = shifted[W-1:0];
        end else if (shifted[2*W-1]) begin
            p_o = {1'b1, {(W-1){1'b0}}};
        end else begin
            p_o = {1'b0, {(W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/chaos_euler_core.sv
// rtl/chaos_euler_core.sv - Euler integrator for Lorenz/Rossler attractors with one shared multiplier
module chaos_euler_core
    import chaos_pkg::*;
#(
    parameter int           W        = 32,
    parameter int           FRAC     = 20,
    parameter int           DT_SHIFT = 8,
    parameter int           DAC_W    = 16,
    parameter logic [W-1:0] X0       = {{(W-1){1'b0}}, 1'b1} << FRAC,
    parameter logic [W-1:0] Y0       = {{(W-1){1'b0}}, 1'b1} << FRAC,
    parameter logic [W-1:0] Z0       = {{(W-1){1'b0}}, 1'b1} << FRAC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_i,
    input  logic                mode_i,
    input  logic                step_req_i,
    input  logic signed [W-1:0] sigma_i,
    input  logic signed [W-1:0] rho_i,
    input  logic signed [W-1:0] beta_i,
    output logic                busy_o,
    output logic                step_done_o,
    output logic                ovf_o,
    output logic signed [W-1:0] x_o,
    output logic signed [W-1:0] y_o,
    output logic signed [W-1:0] z_o,
    output logic [DAC_W-1:0]    dac_x_o,
    output logic [DAC_W-1:0]    dac_y_o,
    output logic [DAC_W-1:0]    dac_z_o
);
    function automatic logic signed [ACC_W-1:0] ext(input logic [W-1:0] v);
        return {{(ACC_W-W){v[W-1]}}, v};
    endfunction

    function automatic logic [DAC_W-1:0] dac_code(input logic [W-1:0] s);
        return {~s[W-1], s[W-2 -: DAC_W-1]};
    endfunction

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic signed [W-1:0] sig_q, sig_d, rho_q, rho_d, beta_q, beta_d;
    logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [W-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic                step_ovf_q, step_ovf_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [DAC_W-1:0]    dac_x_q, dac_x_d, dac_y_q, dac_y_d, dac_z_q, dac_z_d;

    logic signed [W-1:0] mul_a, mul_b, mul_p;
    logic                mul_ovf;
    sat_t                op_s, neg_y, dx, dy, dz, nx, ny, nz;
    logic                upd_ovf;

    fixed_mult_sat #(.W(W), .FRAC(FRAC)) u_mult (
        .a_i   (mul_a),
        .b_i   (mul_b),
        .p_o   (mul_p),
        .ovf_o (mul_ovf)
    );

    // Operand selection for the single multiplier, one product per FSM cycle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        op_s  = '0;
        case (state_q)
            ST_M0: begin
                mul_a = sig_q;
                if (mode_q == MODE_LORENZ) begin
                    op_s  = sat_sub(ext(y_q), ext(x_q), W);
                    mul_b = op_s.val[W-1:0];
                end else begin
                    mul_b = y_q;
                end
            end
            ST_M1: begin
                if (mode_q == MODE_LORENZ) begin
                    op_s  = sat_sub(ext(rho_q), ext(z_q), W);
                    mul_a = x_q;
                end else begin
                    op_s  = sat_sub(ext(x_q), ext(rho_q), W);
                    mul_a = z_q;
                end
                mul_b = op_s.val[W-1:0];
            end
            ST_M2: begin
                mul_a = x_q;
                mul_b = y_q;
            end
            ST_M3: begin
                mul_a = beta_q;
                mul_b = z_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        neg_y = sat_sub('0, ext(y_q), W);
        if (mode_q == MODE_LORENZ) begin
            dx.ovf = 1'b0;
            dx.val = ext(p0_q);
            dy     = sat_sub(ext(p1_q), ext(y_q), W);
            dz     = sat_sub(ext(p2_q), ext(p3_q), W);
        end else begin
            dx     = sat_sub(neg_y.val, ext(z_q), W);
            dx.ovf = dx.ovf | neg_y.ovf;
            dy     = sat_add(ext(x_q), ext(p0_q), W);
            dz     = sat_add(ext(beta_q), ext(p1_q), W);
        end
        nx      = sat_add(ext(x_q), $signed(dx.val) >>> DT_SHIFT, W);
        ny      = sat_add(ext(y_q), $signed(dy.val) >>> DT_SHIFT, W);
        nz      = sat_add(ext(z_q), $signed(dz.val) >>> DT_SHIFT, W);
        upd_ovf = dx.ovf | dy.ovf | dz.ovf | nx.ovf | ny.ovf | nz.ovf;
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        sig_d      = sig_q;
        rho_d      = rho_q;
        beta_d     = beta_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        p0_d       = p0_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        p3_d       = p3_q;
        step_ovf_d = step_ovf_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        if (init_i) begin
            state_d = ST_IDLE;
            x_d     = X0;
            y_d     = Y0;
            z_d     = Z0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (step_req_i) begin
                        state_d    = ST_M0;
                        mode_d     = mode_i;
                        sig_d      = sigma_i;
                        rho_d      = rho_i;
                        beta_d     = beta_i;
                        step_ovf_d = 1'b0;
                    end
                end
                ST_M0: begin
                    p0_d       = mul_p;
                    step_ovf_d = step_ovf_q | op_s.ovf | mul_ovf;
                    state_d    = ST_M1;
                end
                ST_M1: begin
                    p1_d       = mul_p;
                    step_ovf_d = step_ovf_q | op_s.ovf | mul_ovf;
                    state_d    = (mode_q == MODE_LORENZ) ? ST_M2 : ST_UPD;
                end
                ST_M2: begin
                    p2_d       = mul_p;
                    step_ovf_d = step_ovf_q | mul_ovf;
                    state_d    = ST_M3;
                end
                ST_M3: begin
                    p3_d       = mul_p;
                    step_ovf_d = step_ovf_q | mul_ovf;
                    state_d    = ST_UPD;
                end
                ST_UPD: begin
                    // Overflow becomes visible together with the state it affected.
                    x_d     = nx.val[W-1:0];
                    y_d     = ny.val[W-1:0];
                    z_d     = nz.val[W-1:0];
                    ovf_d   = ovf_q | step_ovf_q | upd_ovf;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign dac_x_d = dac_code(x_d);
    assign dac_y_d = dac_code(y_d);
    assign dac_z_d = dac_code(z_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_LORENZ;
            sig_q      <= '0;
            rho_q      <= '0;
            beta_q     <= '0;
            x_q        <= X0;
            y_q        <= Y0;
            z_q        <= Z0;
            p0_q       <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            p3_q       <= '0;
            step_ovf_q <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            dac_x_q    <= dac_code(X0);
            dac_y_q    <= dac_code(Y0);
            dac_z_q    <= dac_code(Z0);
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            sig_q      <= sig_d;
            rho_q      <= rho_d;
            beta_q     <= beta_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            p3_q       <= p3_d;
            step_ovf_q <= step_ovf_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            dac_x_q    <= dac_x_d;
            dac_y_q    <= dac_y_d;
            dac_z_q    <= dac_z_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign step_done_o = done_q;
    assign ovf_o       = ovf_q;
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign z_o         = z_q;
    assign dac_x_o     = dac_x_q;
    assign dac_y_o     = dac_y_q;
    assign dac_z_o     = dac_z_q;
endmodule
